// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: 8 ops on WIDTH-bit operands, RS tag carried alongside.
// Latency STAGES cycles; valid/ready output with full-pipe stall, bubble collapse and flush.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [2:0]                    OP,
  input  logic [WIDTH-1:0]              IN1,
  input  logic [WIDTH-1:0]              IN2,
  input  logic [TAG_W-1:0]              TAG,
  input  logic                          FLUSH,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [WIDTH-1:0]              OUT,
  output logic [TAG_W-1:0]              OUT_TAG,
  output logic                          OUT_ZERO,
  output logic [$clog2(STAGES+1)-1:0]   OCC
);

  localparam int OCC_W = $clog2(STAGES+1);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  data [STAGES];
  logic [TAG_W-1:0]  tag  [STAGES];
  logic [OCC_W-1:0]  occ;
  logic [WIDTH-1:0]  result;
  logic              accept;
  logic              xfer;

  always_comb begin
    result = '0;
    case (op_e'(OP))
      OP_AND:  result = IN1 & IN2;
      OP_OR:   result = IN1 | IN2;
      OP_XOR:  result = IN1 ^ IN2;
      OP_NOR:  result = ~(IN1 | IN2);
      OP_NAND: result = ~(IN1 & IN2);
      OP_XNOR: result = ~(IN1 ^ IN2);
      OP_ANDN: result = IN1 & ~IN2;
      OP_PASS: result = IN1;
      default: result = '0;
    endcase
  end

  // A stage may move when it is empty or everything downstream of it moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v[STAGES-1] | OUT_READY;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = !v[i] | adv[i+1];
    end
  end

  assign IN_READY  = adv[0] & !FLUSH;
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = v[STAGES-1];
  // A handshake coinciding with FLUSH is not a transfer.
  assign xfer      = OUT_VALID & OUT_READY & !FLUSH;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v   <= '0;
      occ <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (FLUSH) begin
      v   <= '0;
      occ <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= accept;
        if (accept) begin
          data[0] <= result;
          tag[0]  <= TAG;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            data[i] <= data[i-1];
            tag[i]  <= tag[i-1];
          end
        end
      end
      if (accept && !xfer) begin
        occ <= occ + 1'b1;
      end else if (!accept && xfer) begin
        occ <= occ - 1'b1;
      end
    end
  end

  assign OUT      = data[STAGES-1];
  assign OUT_TAG  = tag[STAGES-1];
  assign OUT_ZERO = (data[STAGES-1] == '0);
  assign OCC      = occ;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: op table, streaming, stall, flush, reset and a narrow 1-stage instance.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, out_zero;
  logic [2:0]  op;
  logic [31:0] in1, in2, out;
  logic [3:0]  tag, out_tag;
  logic [1:0]  occ;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_zero;
  logic [2:0]  s_op;
  logic [7:0]  s_in1, s_in2, s_out;
  logic [3:0]  s_tag, s_out_tag;
  logic [0:0]  s_occ;

  logic_unit_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(2)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .OP(op),
    .IN1(in1), .IN2(in2), .TAG(tag), .FLUSH(flush), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT(out), .OUT_TAG(out_tag), .OUT_ZERO(out_zero), .OCC(occ)
  );

  logic_unit_pipe #(.WIDTH(8), .TAG_W(4), .STAGES(1)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(s_in_valid), .IN_READY(s_in_ready), .OP(s_op),
    .IN1(s_in1), .IN2(s_in2), .TAG(s_tag), .FLUSH(1'b0), .OUT_VALID(s_out_valid),
    .OUT_READY(1'b1), .OUT(s_out), .OUT_TAG(s_out_tag), .OUT_ZERO(s_out_zero), .OCC(s_occ)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  vec_t vt [8];
  exp_t sbq [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({p, "_out"},       64'(out),       64'd0);
    chk({p, "_out_tag"},   64'(out_tag),   64'd0);
    chk({p, "_out_zero"},  64'(out_zero),  64'd1);
    chk({p, "_occ"},       64'(occ),       64'd0);
    chk({p, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  // Scoreboard: push on accept, pop on transfer; flush/reset discard everything in flight.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got tag %0h data %0h expected no output", out_tag, out);
        end else begin
          e = sbq.pop_front();
          chk("sb_data", 64'(out), 64'(e.d));
          chk("sb_tag", 64'(out_tag), 64'(e.t));
          chk("sb_zero", 64'(out_zero), 64'(e.d == 32'd0));
        end
      end
      if (in_valid && in_ready) sbq.push_back('{d: model(op, in1, in2), t: tag});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int beats, first, last, occ_max, seen;
    logic [31:0] hold;
    logic [3:0]  hold_tag;

    rst = 1; flush = 0; in_valid = 0; op = 0; in1 = 0; in2 = 0; tag = 0; out_ready = 1;
    s_in_valid = 0; s_op = 0; s_in1 = 0; s_in2 = 0; s_tag = 0;
    vt[0] = '{3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vt[1] = '{3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF};
    vt[2] = '{3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB};
    vt[3] = '{3'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000};
    vt[4] = '{3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB};
    vt[5] = '{3'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00FF_1234};
    vt[6] = '{3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF000_0000};
    vt[7] = '{3'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234};

    cyc(); cyc(); rst = 0;
    @(negedge clk);
    check_reset("reset");
    chk("reset_s_out_valid", 64'(s_out_valid), 64'd0);
    chk("reset_s_out_zero", 64'(s_out_zero), 64'd1);

    // 1: each op, exact 2-cycle latency
    for (int i = 0; i < 8; i++) begin
      cyc(); in_valid = 1; op = vt[i].op; in1 = vt[i].a; in2 = vt[i].b; tag = 4'(i);
      @(negedge clk); chk("t1_in_ready", 64'(in_ready), 64'd1);
      cyc(); in_valid = 0; op = 'x;
      @(negedge clk); chk("t1_early_valid", 64'(out_valid), 64'd0);
      cyc();
      @(negedge clk);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_result", 64'(out), 64'(vt[i].exp));
      chk("t1_tag", 64'(out_tag), 64'(i));
    end
    op = 0;

    // 2: stream 10 ops back to back
    beats = 0; first = -1; last = -1; occ_max = 0;
    for (int k = 0; k < 14; k++) begin
      cyc();
      if (k < 10) begin
        in_valid = 1; op = 3'(k % 8); in1 = $urandom; in2 = $urandom; tag = 4'(k);
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
      if (out_valid) begin
        chk("t2_tag_order", 64'(out_tag), 64'(beats));
        beats++;
        if (first < 0) first = k;
        last = k;
      end
      if (int'(occ) > occ_max) occ_max = int'(occ);
    end
    chk("t2_beats", 64'(beats), 64'd10);
    chk("t2_consecutive", 64'(last - first), 64'd9);
    chk("t2_occ_peak", 64'(occ_max), 64'd2);

    // 3: fill with OUT_READY low, hold, then a single transfer
    cyc(); out_ready = 0; in_valid = 1; op = 3'd2; in1 = 32'h1234_5678; in2 = 32'h0F0F_0F0F; tag = 4'd1;
    @(negedge clk); chk("t3_rdy_a", 64'(in_ready), 64'd1);
    cyc(); op = 3'd6; in1 = 32'hDEAD_BEEF; in2 = 32'h0000_FFFF; tag = 4'd2;
    @(negedge clk); chk("t3_rdy_b", 64'(in_ready), 64'd1);
    cyc(); op = 3'd1; in1 = 32'h0000_0001; in2 = 32'h8000_0000; tag = 4'd3;
    @(negedge clk);
    chk("t3_full_occ", 64'(occ), 64'd2);
    chk("t3_full_rdy", 64'(in_ready), 64'd0);
    chk("t3_full_valid", 64'(out_valid), 64'd1);
    hold = out; hold_tag = out_tag;
    cyc(); in1 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t3_hold_out", 64'(out), 64'(hold));
    chk("t3_hold_tag", 64'(out_tag), 64'(hold_tag));
    chk("t3_hold_occ", 64'(occ), 64'd2);
    cyc(); out_ready = 1; in1 = 32'h0000_0001;
    @(negedge clk); chk("t3_rdy_on_xfer", 64'(in_ready), 64'd1);
    cyc(); out_ready = 0; in_valid = 0;
    @(negedge clk);
    chk("t3_occ_after", 64'(occ), 64'd2);
    chk("t3_next_tag", 64'(out_tag), 64'd2);
    cyc(); out_ready = 1;
    cyc(); cyc();
    @(negedge clk); chk("t3_drained", 64'(occ), 64'd0);

    // 4: flush with two in flight and a presented op
    cyc(); out_ready = 0; in_valid = 1; op = 3'd0; in1 = 32'hAAAA_5555; in2 = 32'hFFFF_0000; tag = 4'd4;
    cyc(); tag = 4'd5;
    cyc(); flush = 1; tag = 4'hF;
    @(negedge clk);
    chk("t4_flush_rdy", 64'(in_ready), 64'd0);
    chk("t4_occ_before", 64'(occ), 64'd2);
    cyc(); flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_occ", 64'(occ), 64'd0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t4_no_emerge", 64'(seen), 64'd0);

    // 5: reset together with flush mid-stream, then resume
    for (int k = 0; k < 3; k++) begin
      cyc(); in_valid = 1; op = 3'(k + 3); in1 = $urandom; in2 = $urandom; tag = 4'(k);
    end
    cyc(); rst = 1; flush = 1; tag = 4'hE;
    cyc(); rst = 0; flush = 0; in_valid = 0;
    @(negedge clk);
    check_reset("t5");
    beats = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k < 3) begin
        in_valid = 1; op = 3'(k); in1 = $urandom; in2 = $urandom; tag = 4'(k + 6);
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
      if (out_valid) beats++;
    end
    chk("t5_resume_beats", 64'(beats), 64'd3);

    // 6: narrow single-stage instance
    cyc(); s_in_valid = 1; s_op = 3'b011; s_in1 = 8'h00; s_in2 = 8'h00; s_tag = 4'd3;
    cyc(); s_op = 3'b000; s_in1 = 8'hAA; s_in2 = 8'h55; s_tag = 4'd4;
    @(negedge clk);
    chk("t6_nor_valid", 64'(s_out_valid), 64'd1);
    chk("t6_nor_out", 64'(s_out), 64'hFF);
    chk("t6_nor_zero", 64'(s_out_zero), 64'd0);
    chk("t6_nor_tag", 64'(s_out_tag), 64'd3);
    cyc(); s_in_valid = 0;
    @(negedge clk);
    chk("t6_and_valid", 64'(s_out_valid), 64'd1);
    chk("t6_and_out", 64'(s_out), 64'h00);
    chk("t6_and_zero", 64'(s_out_zero), 64'd1);
    cyc();
    @(negedge clk);
    chk("t6_idle_valid", 64'(s_out_valid), 64'd0);
    chk("t6_idle_occ", 64'(s_occ), 64'd0);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
